// File: rtl/gestor_alarma_critica_if.sv
`default_nettype none
// ============================================================================
//  Module      : gestor_alarma_critica_if
//  Description : Bundle between the critical-charge comparator / operator
//                panel (master) and the critical alarm manager (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface gestor_alarma_critica_if #(
    parameter int CNT_W = 8
);
    logic             advertencia_critica;
    logic [4:0]       carga_total;
    logic             reconocer;
    logic             alarma_activa;
    logic             alarma_pendiente;
    logic [4:0]       carga_minima;
    logic [CNT_W-1:0] num_eventos;
    logic             led_alarma;

    modport master (
        output advertencia_critica,
        output carga_total,
        output reconocer,
        input  alarma_activa,
        input  alarma_pendiente,
        input  carga_minima,
        input  num_eventos,
        input  led_alarma
    );

    modport slave (
        input  advertencia_critica,
        input  carga_total,
        input  reconocer,
        output alarma_activa,
        output alarma_pendiente,
        output carga_minima,
        output num_eventos,
        output led_alarma
    );
endinterface
`default_nettype wire

// File: rtl/gestor_alarma_critica.sv
`default_nettype none
// ============================================================================
//  Module      : gestor_alarma_critica
//  Description : Debounces the critical-charge warning, holds the alarm with
//                release hysteresis, latches a pending flag until the
//                operator acknowledges it, tracks the minimum charge of the
//                latest episode and counts alarm entries (saturating).
//                Optional blinking LED selected by macro ALARMA_PARPADEO_EN;
//                without it the LED is a registered OR of active/pending.
//  Revision    : 1.0 - initial release
// ============================================================================
module gestor_alarma_critica #(
    parameter int DEBOUNCE_CICLOS = 4,
    parameter int LIBERA_CICLOS   = 8,
    parameter int PARPADEO_DIV    = 16,
    parameter int CNT_W           = 8
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    gestor_alarma_critica_if.slave bus
);

    typedef enum logic [1:0] {
        ST_NORMAL   = 2'd0,
        ST_SOSPECHA = 2'd1,
        ST_ALARMA   = 2'd2,
        ST_RECUPERA = 2'd3
    } estado_t;

    // One counter serves both the debounce and the release windows
    localparam int c_MAXC = (DEBOUNCE_CICLOS > LIBERA_CICLOS) ? DEBOUNCE_CICLOS : LIBERA_CICLOS;
    localparam int c_CW   = $clog2(c_MAXC + 1);
    localparam logic [c_CW-1:0] c_DEB_LAST = c_CW'(DEBOUNCE_CICLOS - 1);
    localparam logic [c_CW-1:0] c_LIB_LAST = c_CW'(LIBERA_CICLOS - 1);

    estado_t          r_estado;
    logic [c_CW-1:0]  r_cnt;
    logic [4:0]       r_min_sosp;
    logic             r_activa;
    logic             r_pend;
    logic [4:0]       r_min;
    logic [CNT_W-1:0] r_eventos;
    logic             r_led;

    estado_t          w_estado_nxt;
    logic [c_CW-1:0]  w_cnt_nxt;
    logic [4:0]       w_min_sosp_nxt;
    logic [4:0]       w_min_nxt;
    logic             w_entrada;
    logic             w_activa_nxt;
    logic             w_pend_nxt;

    function automatic logic [4:0] f_min(input logic [4:0] a, input logic [4:0] b);
        return (a < b) ? a : b;
    endfunction

    // State register and window counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado   <= ST_NORMAL;
            r_cnt      <= '0;
            r_min_sosp <= 5'h1F;
        end else begin
            r_estado   <= w_estado_nxt;
            r_cnt      <= w_cnt_nxt;
            r_min_sosp <= w_min_sosp_nxt;
        end
    end

    // Next-state, counter and running-minimum logic
    always_comb begin
        w_estado_nxt   = r_estado;
        w_cnt_nxt      = r_cnt;
        w_min_sosp_nxt = r_min_sosp;
        w_min_nxt      = r_min;
        w_entrada      = 1'b0;
        case (r_estado)
            ST_NORMAL: begin
                w_cnt_nxt = '0;
                if (bus.advertencia_critica) begin
                    w_min_sosp_nxt = bus.carga_total;
                    if (DEBOUNCE_CICLOS == 1) begin
                        w_estado_nxt = ST_ALARMA;
                        w_entrada    = 1'b1;
                        w_min_nxt    = bus.carga_total;
                    end else begin
                        w_estado_nxt = ST_SOSPECHA;
                        w_cnt_nxt    = c_CW'(1);
                    end
                end
            end
            ST_SOSPECHA: begin
                if (!bus.advertencia_critica) begin
                    w_estado_nxt = ST_NORMAL;
                    w_cnt_nxt    = '0;
                end else if (r_cnt == c_DEB_LAST) begin
                    w_estado_nxt = ST_ALARMA;
                    w_cnt_nxt    = '0;
                    w_entrada    = 1'b1;
                    w_min_nxt    = f_min(r_min_sosp, bus.carga_total);
                end else begin
                    w_cnt_nxt      = r_cnt + c_CW'(1);
                    w_min_sosp_nxt = f_min(r_min_sosp, bus.carga_total);
                end
            end
            ST_ALARMA: begin
                if (bus.advertencia_critica) begin
                    w_min_nxt = f_min(r_min, bus.carga_total);
                end else if (LIBERA_CICLOS == 1) begin
                    w_estado_nxt = ST_NORMAL;
                    w_cnt_nxt    = '0;
                end else begin
                    w_estado_nxt = ST_RECUPERA;
                    w_cnt_nxt    = c_CW'(1);
                end
            end
            ST_RECUPERA: begin
                if (bus.advertencia_critica) begin
                    // Warning returned before release: same episode, no new event
                    w_estado_nxt = ST_ALARMA;
                    w_cnt_nxt    = '0;
                    w_min_nxt    = f_min(r_min, bus.carga_total);
                end else if (r_cnt == c_LIB_LAST) begin
                    w_estado_nxt = ST_NORMAL;
                    w_cnt_nxt    = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_CW'(1);
                end
            end
            default: begin
                w_estado_nxt = ST_NORMAL;
                w_cnt_nxt    = '0;
            end
        endcase
        w_activa_nxt = (w_estado_nxt == ST_ALARMA) || (w_estado_nxt == ST_RECUPERA);
        // A fresh alarm entry overrides a simultaneous acknowledge
        w_pend_nxt   = w_entrada ? 1'b1 : (bus.reconocer ? 1'b0 : r_pend);
    end

    // Registered alarm flags, episode minimum and saturating event counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_activa  <= 1'b0;
            r_pend    <= 1'b0;
            r_min     <= 5'h1F;
            r_eventos <= '0;
        end else begin
            r_activa <= w_activa_nxt;
            r_pend   <= w_pend_nxt;
            r_min    <= w_min_nxt;
            if (w_entrada && (r_eventos != {CNT_W{1'b1}})) begin
                r_eventos <= r_eventos + CNT_W'(1);
            end
        end
    end

`ifdef ALARMA_PARPADEO_EN
    localparam int c_DW = (PARPADEO_DIV > 1) ? $clog2(PARPADEO_DIV) : 1;
    localparam logic [c_DW-1:0] c_DIV_LAST = c_DW'(PARPADEO_DIV - 1);

    logic [c_DW-1:0] r_div;

    // Blink while active (restarting lit on entry), steady while only pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led <= 1'b0;
            r_div <= '0;
        end else if (w_entrada) begin
            r_led <= 1'b1;
            r_div <= '0;
        end else if (w_activa_nxt) begin
            if (r_div == c_DIV_LAST) begin
                r_div <= '0;
                r_led <= ~r_led;
            end else begin
                r_div <= r_div + c_DW'(1);
            end
        end else if (w_pend_nxt) begin
            r_led <= 1'b1;
            r_div <= '0;
        end else begin
            r_led <= 1'b0;
            r_div <= '0;
        end
    end
`else
    // Divider parameter has no effect in this build
    logic w_unused_div;
    assign w_unused_div = ^PARPADEO_DIV;

    // LED follows active-or-pending one cycle late
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led <= 1'b0;
        end else begin
            r_led <= r_activa | r_pend;
        end
    end
`endif

    assign bus.alarma_activa    = r_activa;
    assign bus.alarma_pendiente = r_pend;
    assign bus.carga_minima     = r_min;
    assign bus.num_eventos      = r_eventos;
    assign bus.led_alarma       = r_led;

endmodule
`default_nettype wire

// File: tb/tb_gestor_alarma_critica.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gestor_alarma_critica
//  Description : Directed self-checking bench for gestor_alarma_critica.
//                A second instance with CNT_W=2 shares the stimulus to
//                exercise event-counter saturation. LED expectations follow
//                ALARMA_PARPADEO_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gestor_alarma_critica;

`ifdef ALARMA_PARPADEO_EN
    localparam bit c_BLINK = 1'b1;
`else
    localparam bit c_BLINK = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    gestor_alarma_critica_if #(.CNT_W(8)) bus  ();
    gestor_alarma_critica_if #(.CNT_W(2)) bus2 ();

    gestor_alarma_critica #(
        .DEBOUNCE_CICLOS(4), .LIBERA_CICLOS(8), .PARPADEO_DIV(4), .CNT_W(8)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    gestor_alarma_critica #(
        .DEBOUNCE_CICLOS(4), .LIBERA_CICLOS(8), .PARPADEO_DIV(4), .CNT_W(2)
    ) u_dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    assign bus2.advertencia_critica = bus.advertencia_critica;
    assign bus2.carga_total         = bus.carga_total;
    assign bus2.reconocer           = bus.reconocer;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.advertencia_critica = 1'b0;
        bus.carga_total         = 5'd0;
        bus.reconocer           = 1'b0;
        step();
        step();
        chk("rst_activa", bus.alarma_activa,    1'b0);
        chk("rst_pend",   bus.alarma_pendiente, 1'b0);
        chk("rst_min",    bus.carga_minima,     5'h1F);
        chk("rst_ev",     bus.num_eventos,      8'd0);
        chk("rst_led",    bus.led_alarma,       1'b0);
        rst_n = 1'b1;

        // Three-sample glitch is filtered
        bus.advertencia_critica = 1'b1;
        bus.carga_total = 5'd10;
        repeat (3) step();
        chk("t1_activa_3hi", bus.alarma_activa, 1'b0);
        bus.advertencia_critica = 1'b0;
        step();
        chk("t1_activa", bus.alarma_activa, 1'b0);
        chk("t1_ev",     bus.num_eventos,   8'd0);
        chk("t1_min",    bus.carga_minima,  5'h1F);

        // Four highs raise the alarm, minimum over the suspicion window
        bus.advertencia_critica = 1'b1;
        bus.carga_total = 5'd3; step();
        bus.carga_total = 5'd2; step();
        bus.carga_total = 5'd1; step();
        chk("t2_activa_3hi", bus.alarma_activa, 1'b0);
        bus.carga_total = 5'd2; step();
        chk("t2_activa", bus.alarma_activa,    1'b1);
        chk("t2_pend",   bus.alarma_pendiente, 1'b1);
        chk("t2_ev",     bus.num_eventos,      8'd1);
        chk("t2_min",    bus.carga_minima,     5'd1);
        chk("t2_led",    bus.led_alarma,       c_BLINK ? 1'b1 : 1'b0);

        // Hysteresis: 7 lows hold, re-high does not count, 8 lows release
        bus.advertencia_critica = 1'b0;
        repeat (7) step();
        chk("t3_activa_7lo", bus.alarma_activa, 1'b1);
        bus.advertencia_critica = 1'b1;
        bus.carga_total = 5'd0;
        step();
        chk("t3_activa_rehi", bus.alarma_activa, 1'b1);
        chk("t3_min_rehi",    bus.carga_minima,  5'd0);
        chk("t3_ev_rehi",     bus.num_eventos,   8'd1);
        bus.advertencia_critica = 1'b0;
        repeat (7) step();
        chk("t3_activa_7lo_b", bus.alarma_activa, 1'b1);
        step();
        chk("t3_activa_off", bus.alarma_activa,    1'b0);
        chk("t3_pend",       bus.alarma_pendiente, 1'b1);
        chk("t3_min_hold",   bus.carga_minima,     5'd0);

        // Acknowledge in NORMAL
        bus.reconocer = 1'b1;
        step();
        bus.reconocer = 1'b0;
        chk("t4a_pend",   bus.alarma_pendiente, 1'b0);
        chk("t4a_activa", bus.alarma_activa,    1'b0);
        step();
        chk("t4a_led", bus.led_alarma, 1'b0);

        // Acknowledge coincident with entry: set wins
        bus.advertencia_critica = 1'b1;
        bus.carga_total = 5'd20;
        repeat (3) step();
        bus.reconocer = 1'b1;
        step();
        bus.reconocer = 1'b0;
        chk("t4b_pend",   bus.alarma_pendiente, 1'b1);
        chk("t4b_ev",     bus.num_eventos,      8'd2);
        chk("t4b_min",    bus.carga_minima,     5'd20);
        chk("t4b_activa", bus.alarma_activa,    1'b1);
        bus.carga_total = 5'd25;
        step();
        chk("t4b_min_hold", bus.carga_minima, 5'd20);
        bus.reconocer = 1'b1;
        step();
        bus.reconocer = 1'b0;
        chk("t4b_ack_pend",   bus.alarma_pendiente, 1'b0);
        chk("t4b_ack_activa", bus.alarma_activa,    1'b1);

        // Asynchronous reset between edges while in alarm
        #3;
        rst_n = 1'b0;
        #1;
        chk("t5_activa", bus.alarma_activa,    1'b0);
        chk("t5_pend",   bus.alarma_pendiente, 1'b0);
        chk("t5_min",    bus.carga_minima,     5'h1F);
        chk("t5_ev",     bus.num_eventos,      8'd0);
        chk("t5_led",    bus.led_alarma,       1'b0);
        bus.advertencia_critica = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        bus.advertencia_critica = 1'b1;
        bus.carga_total = 5'd7;
        repeat (3) step();
        chk("t5_re_3hi", bus.alarma_activa, 1'b0);
        step();
        chk("t5_re_activa", bus.alarma_activa, 1'b1);
        chk("t5_re_ev",     bus.num_eventos,   8'd1);
        chk("t5_re_min",    bus.carga_minima,  5'd7);

        // Five more episodes: wide counter reaches 6, narrow one sticks at 3
        bus.advertencia_critica = 1'b0;
        repeat (8) step();
        chk("t6a_clear", bus.alarma_activa, 1'b0);
        for (int ep = 0; ep < 5; ep++) begin
            bus.advertencia_critica = 1'b1;
            bus.carga_total = 5'(ep + 5);
            repeat (4) step();
            bus.advertencia_critica = 1'b0;
            repeat (8) step();
            if (ep == 2) chk("t6a_sat_ep3", bus2.num_eventos, 2'd3);
        end
        chk("t6a_sat",    bus2.num_eventos, 2'd3);
        chk("t6a_ev",     bus.num_eventos,  8'd6);
        chk("t6a_activa", bus.alarma_activa, 1'b0);

        // LED pattern from a clean start
        bus.reconocer = 1'b1;
        step();
        bus.reconocer = 1'b0;
        chk("t6b_led_ack", bus.led_alarma, c_BLINK ? 1'b0 : 1'b1);
        step();
        chk("t6b_led_idle", bus.led_alarma, 1'b0);
        bus.advertencia_critica = 1'b1;
        bus.carga_total = 5'd9;
        repeat (4) step();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t6b_led_blink%0d", i), bus.led_alarma,
                c_BLINK ? ((i < 4) ? 1'b1 : 1'b0) : ((i != 0) ? 1'b1 : 1'b0));
            if (i < 7) step();
        end
        bus.advertencia_critica = 1'b0;
        repeat (8) step();
        chk("t6b_activa_off", bus.alarma_activa, 1'b0);
        chk("t6b_led_pend0",  bus.led_alarma,    1'b1);
        step();
        chk("t6b_led_pend1",  bus.led_alarma,    1'b1);
        bus.reconocer = 1'b1;
        step();
        bus.reconocer = 1'b0;
        chk("t6b_led_ack2", bus.led_alarma, c_BLINK ? 1'b0 : 1'b1);
        step();
        chk("t6b_led_off", bus.led_alarma, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
